punc_debug_dumper: RTL and testbench
====================================

// Module: punc_debug_dumper
// PURPOSE
//  Snapshot engine that sits directly downstream of the PUnC top level on its debug
//  ports. On a start pulse it reads the PC, then R0..R7, then a window of memory
//  through the debug port. It streams each 16-bit word out on a valid/ready
//  interface with a section tag, for the testbench monitor or a host UART bridge.
// PARAMETERS
//  MEM_RD_LAT  0  cycles from mem_debug_addr change to valid mem_debug_data (0 or 1)
//  INCLUDE_RF  1  1: emit PC + R0..R7 before memory; 0: emit PC then memory only
// PORTS
//  clk             in   1   clock; all state updates on posedge
//  rst             in   1   asynchronous, active-high reset
//  start           in   1   1-cycle request; sampled only in IDLE
//  start_addr      in   16  first memory address of window (latched at start)
//  count           in   16  number of memory words to emit (latched at start)
//  mem_debug_addr  out  16  to PUnC mem_debug_addr
//  mem_debug_data  in   16  from PUnC mem_debug_data
//  rf_debug_addr   out  3   to PUnC rf_debug_addr (combinational read)
//  rf_debug_data   in   16  from PUnC rf_debug_data
//  pc_debug_data   in   16  from PUnC pc_debug_data
//  out_valid       out  1   out_data/out_tag valid
//  out_ready       in   1   consumer accepts when out_valid & out_ready
//  out_data        out  16  word being presented
//  out_tag         out  2   00 PC, 01 RF, 10 MEM, 11 unused
//  busy            out  1   high from cycle after accepted start until DONE exits
//  done            out  1   1-cycle pulse after last word accepted
// BEHAVIOUR
//  - Reset (async, any state): FSM=IDLE; mem_debug_addr, rf_debug_addr, out_data,
//    out_tag, out_valid, busy, done all 0; internal counters 0.
//  - FSM: IDLE -> FETCH -> PRESENT -> (FETCH | DONE) -> IDLE.
//    IDLE: start=1 latches start_addr/count, section=PC, go FETCH.
//    FETCH: debug addrs driven from registers. PC/RF words are captured after 1 cycle.
//      MEM words are captured after 1+MEM_RD_LAT cycles (wait counter). Captured word
//      goes into out_data and out_tag, then go PRESENT.
//    PRESENT: out_valid=1; out_data/out_tag held stable until handshake. On handshake,
//      advance: PC -> RF idx 0 (or MEM if INCLUDE_RF=0); RF idx 7 -> MEM.
//      MEM: addr+1, remaining-1. Go FETCH, or go DONE if nothing remains.
//    DONE: done=1, busy=1 for exactly one cycle; then IDLE with busy=0.
//  - Sections with count=0: MEM section skipped entirely; DONE follows the last RF word.
//    With INCLUDE_RF=0, DONE follows the PC word.
//  - Address arithmetic is 16-bit modulo: 0xFFFF + 1 wraps to 0x0000. No error flag.
//  - Throughput: at best one word per 2 cycles (PC/RF) or 2+MEM_RD_LAT cycles (MEM).
//  - start while not IDLE is ignored. start_addr/count changes after latch are ignored.
//  - out_valid never deasserts without a handshake. out_ready while out_valid=0 is ignored.
//  - Total words = 1 + 8*INCLUDE_RF + count. The FSM does not stall the processor.
//    Snapshot coherence is the user's responsibility (hold PUnC in a stable state).
//  - Reset mid-dump aborts immediately. No done pulse. The next start restarts from PC.
// TESTING
//  1 PC=0x3000, Ri=0x0010*i, mem[0x3000..2]=AAAA,BBBB,CCCC; start addr=0x3000 cnt=3,
//    out_ready=1 -> 12 words: 3000(tag0), 0000..0070(tag1), AAAA,BBBB,CCCC(tag2); done once
//  2 Same, out_ready held 0 for 5 cycles on R3 -> out_valid stays 1, out_data=0x0030
//    stable; sequence otherwise unchanged
//  3 start_addr=0xFFFE cnt=4 -> mem_debug_addr visits FFFE,FFFF,0000,0001 in order
//  4 cnt=0, INCLUDE_RF=1 -> exactly 9 words; done pulses the cycle after R7 is accepted
//  5 start pulsed during MEM section -> ignored; rst asserted mid-MEM -> all outputs 0
//    same cycle; new start -> full dump from PC
//  6 MEM_RD_LAT=1, registered memory model -> every MEM word matches its own address

Source files
------------

// File: rtl/punc_debug_dumper_if.sv
// Output word stream of the PUnC debug dumper.
// Handshake: the master raises out_valid with out_data/out_tag and holds all
// three stable until a cycle in which out_valid & out_ready are both high; that
// cycle transfers the word. out_ready while out_valid is low has no effect.
interface punc_debug_dumper_if;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [1:0]  out_tag;

  modport master (
    output out_valid,
    output out_data,
    output out_tag,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_tag,
    output out_ready
  );
endinterface

// File: rtl/punc_debug_dumper.sv
// Snapshot engine for the PUnC debug ports: on start it streams the PC,
// optionally R0..R7, then a window of memory, one tagged word at a time.
module punc_debug_dumper #(
  parameter int MEM_RD_LAT = 0,  // 0: combinational memory read, 1: registered
  parameter bit INCLUDE_RF = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] start_addr,
  input  logic [15:0] count,
  output logic [15:0] mem_debug_addr,
  input  logic [15:0] mem_debug_data,
  output logic [2:0]  rf_debug_addr,
  input  logic [15:0] rf_debug_data,
  input  logic [15:0] pc_debug_data,
  punc_debug_dumper_if.master out_if,
  output logic        busy,
  output logic        done,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FETCH   = 2'd1,
    S_PRESENT = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  // Section encoding doubles as the output tag.
  typedef enum logic [1:0] {
    SEC_PC  = 2'b00,
    SEC_RF  = 2'b01,
    SEC_MEM = 2'b10
  } sec_t;

  // Value of wait_cnt on the cycle a memory word is valid.
  localparam logic WAIT_LAST = 1'(MEM_RD_LAT != 0);

  state_t      state, state_next;
  sec_t        section;
  logic [2:0]  rf_idx;
  logic [15:0] mem_addr;
  logic [15:0] remaining;
  logic        wait_cnt;
  logic [15:0] data_q;
  logic [1:0]  tag_q;

  logic        launch;
  logic        capture;
  logic        advance;
  logic        fetch_last;
  logic        last_word;
  logic [15:0] fetch_word;

  assign mem_debug_addr   = mem_addr;
  assign rf_debug_addr    = rf_idx;
  assign out_if.out_valid = (state == S_PRESENT);
  assign out_if.out_data  = data_q;
  assign out_if.out_tag   = tag_q;
  assign busy             = (state != S_IDLE);
  assign done             = (state == S_DONE);
  assign dbg_state        = state;

  // Source word selection, fetch completion and end-of-dump detection.
  always_comb begin
    fetch_word = pc_debug_data;
    fetch_last = 1'b1;
    last_word  = 1'b0;
    case (section)
      SEC_PC: begin
        fetch_word = pc_debug_data;
        last_word  = !INCLUDE_RF && (remaining == 16'd0);
      end
      SEC_RF: begin
        fetch_word = rf_debug_data;
        last_word  = (rf_idx == 3'd7) && (remaining == 16'd0);
      end
      SEC_MEM: begin
        fetch_word = mem_debug_data;
        fetch_last = (wait_cnt == WAIT_LAST);
        last_word  = (remaining == 16'd1);
      end
      default: begin
        fetch_word = pc_debug_data;
      end
    endcase
  end

  // Next-state logic and datapath strobes.
  always_comb begin
    state_next = state;
    launch     = 1'b0;
    capture    = 1'b0;
    advance    = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          launch     = 1'b1;
          state_next = S_FETCH;
        end
      end
      S_FETCH: begin
        if (fetch_last) begin
          capture    = 1'b1;
          state_next = S_PRESENT;
        end
      end
      S_PRESENT: begin
        if (out_if.out_ready) begin
          advance    = 1'b1;
          state_next = last_word ? S_DONE : S_FETCH;
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // State register; reset aborts any dump in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Window registers, section walk and the presented word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      section   <= SEC_PC;
      rf_idx    <= 3'd0;
      mem_addr  <= 16'd0;
      remaining <= 16'd0;
      wait_cnt  <= 1'b0;
      data_q    <= 16'd0;
      tag_q     <= 2'b00;
    end else begin
      if (launch) begin
        section   <= SEC_PC;
        rf_idx    <= 3'd0;
        mem_addr  <= start_addr;
        remaining <= count;
        wait_cnt  <= 1'b0;
      end
      if (state == S_FETCH) begin
        if (capture) begin
          data_q   <= fetch_word;
          tag_q    <= section;
          wait_cnt <= 1'b0;
        end else begin
          wait_cnt <= wait_cnt + 1'b1;
        end
      end
      if (advance) begin
        case (section)
          SEC_PC: begin
            if (INCLUDE_RF) begin
              section <= SEC_RF;
              rf_idx  <= 3'd0;
            end else begin
              section <= SEC_MEM;
            end
          end
          SEC_RF: begin
            if (rf_idx == 3'd7) section <= SEC_MEM;
            else                rf_idx  <= rf_idx + 3'd1;
          end
          SEC_MEM: begin
            // 16-bit wrap is intended: FFFF is followed by 0000.
            mem_addr  <= mem_addr + 16'd1;
            remaining <= remaining - 16'd1;
          end
          default: section <= SEC_PC;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_punc_debug_dumper.sv
// Bench for punc_debug_dumper: one instance with combinational memory, one
// with a registered memory (MEM_RD_LAT=1). A vector table drives whole dumps;
// hand-written sequences cover reset values and reset in the middle of a dump.
module tb_punc_debug_dumper;

  typedef struct {
    int          sel;         // 0: comb-memory DUT, 1: registered-memory DUT
    logic [15:0] start_addr;
    logic [15:0] count;
    int          stall_idx;   // word index held with out_ready=0 (-1: none)
    int          stall_cyc;
    int          inject_idx;  // word index at which a stray start is pulsed
    int          exp_words;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- stimulus signals ----------------
  int          sel = 0;
  logic        start = 1'b0;
  logic [15:0] start_addr = 16'd0;
  logic [15:0] count = 16'd0;
  logic        ready = 1'b1;

  logic [15:0] pc_data;
  logic [15:0] mem_addr0, mem_addr1, mem_data0;
  logic [15:0] mem_data1 = 16'd0;
  logic [2:0]  rf_addr0, rf_addr1;
  logic [15:0] rf_data0, rf_data1;
  logic        busy0, busy1, done0, done1;
  logic [1:0]  dbg0, dbg1;

  punc_debug_dumper_if if0 ();
  punc_debug_dumper_if if1 ();

  assign if0.out_ready = ready;
  assign if1.out_ready = ready;
  assign pc_data  = 16'h3000;
  assign rf_data0 = {9'd0, rf_addr0, 4'd0};
  assign rf_data1 = {9'd0, rf_addr1, 4'd0};

  function automatic logic [15:0] mem_f(input logic [15:0] a);
    case (a)
      16'h3000: mem_f = 16'hAAAA;
      16'h3001: mem_f = 16'hBBBB;
      16'h3002: mem_f = 16'hCCCC;
      default:  mem_f = ~a;
    endcase
  endfunction

  assign mem_data0 = mem_f(mem_addr0);
  // Registered memory whose content equals its address.
  always @(posedge clk) mem_data1 <= mem_addr1;

  punc_debug_dumper #(.MEM_RD_LAT(0), .INCLUDE_RF(1'b1)) dut0 (
    .clk(clk), .rst(rst), .start(start && (sel == 0)),
    .start_addr(start_addr), .count(count),
    .mem_debug_addr(mem_addr0), .mem_debug_data(mem_data0),
    .rf_debug_addr(rf_addr0), .rf_debug_data(rf_data0),
    .pc_debug_data(pc_data), .out_if(if0),
    .busy(busy0), .done(done0), .dbg_state(dbg0)
  );

  punc_debug_dumper #(.MEM_RD_LAT(1), .INCLUDE_RF(1'b1)) dut1 (
    .clk(clk), .rst(rst), .start(start && (sel == 1)),
    .start_addr(start_addr), .count(count),
    .mem_debug_addr(mem_addr1), .mem_debug_data(mem_data1),
    .rf_debug_addr(rf_addr1), .rf_debug_data(rf_data1),
    .pc_debug_data(pc_data), .out_if(if1),
    .busy(busy1), .done(done1), .dbg_state(dbg1)
  );

  logic        cur_valid, cur_busy, cur_done;
  logic [15:0] cur_data, cur_mem_addr;
  logic [1:0]  cur_tag;
  assign cur_valid    = (sel == 1) ? if1.out_valid : if0.out_valid;
  assign cur_data     = (sel == 1) ? if1.out_data  : if0.out_data;
  assign cur_tag      = (sel == 1) ? if1.out_tag   : if0.out_tag;
  assign cur_busy     = (sel == 1) ? busy1 : busy0;
  assign cur_done     = (sel == 1) ? done1 : done0;
  assign cur_mem_addr = (sel == 1) ? mem_addr1 : mem_addr0;

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_valid"}, {31'd0, if0.out_valid}, 32'd0);
    check({name, "_data"},  {16'd0, if0.out_data}, 32'd0);
    check({name, "_tag"},   {30'd0, if0.out_tag}, 32'd0);
    check({name, "_busy"},  {31'd0, busy0}, 32'd0);
    check({name, "_done"},  {31'd0, done0}, 32'd0);
    check({name, "_maddr"}, {16'd0, mem_addr0}, 32'd0);
    check({name, "_raddr"}, {29'd0, rf_addr0}, 32'd0);
  endtask

  // ---------------- driver + monitor for one dump ----------------
  task automatic run_dump(input vec_t v, input int vid);
    logic [17:0] exp_q[$];
    logic [15:0] exp_addr_q[$];
    logic [15:0] a;
    logic [17:0] e;
    int words, last_hs, cyc, stall_left;
    bit injected, finished;
    words = 0; last_hs = -10; cyc = 0; stall_left = v.stall_cyc;
    injected = 1'b0; finished = 1'b0;
    sel = v.sel;
    exp_q.push_back({2'b00, 16'h3000});
    for (int i = 0; i < 8; i++) exp_q.push_back({2'b01, 16'(i * 16)});
    for (int i = 0; i < int'(v.count); i++) begin
      a = v.start_addr + 16'(i);
      exp_q.push_back({2'b10, (v.sel == 1) ? a : mem_f(a)});
      exp_addr_q.push_back(a);
    end

    @(negedge clk);
    start = 1'b1; start_addr = v.start_addr; count = v.count; ready = 1'b1;
    @(negedge clk);
    start = 1'b0; start_addr = 16'h0BAD; count = 16'h0007;
    check($sformatf("v%0d_busy_after_start", vid), {31'd0, cur_busy}, 32'd1);

    while (!finished && cyc < 400) begin
      start = 1'b0;
      ready = 1'b1;
      if (cur_valid && words == v.stall_idx && stall_left > 0) begin
        ready = 1'b0;
        stall_left--;
        if (exp_q.size() > 0)
          check($sformatf("v%0d_stall_hold", vid), {14'd0, cur_tag, cur_data}, {14'd0, exp_q[0]});
      end
      if (cur_valid && words == v.inject_idx && !injected) begin
        start = 1'b1; start_addr = 16'h0100; injected = 1'b1;
      end
      if (cur_valid && ready) begin
        if (exp_q.size() == 0) begin
          check($sformatf("v%0d_extra_word", vid), 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("v%0d_word%0d", vid, words), {14'd0, cur_tag, cur_data}, {14'd0, e});
          if (cur_tag == 2'b10 && exp_addr_q.size() > 0)
            check($sformatf("v%0d_maddr%0d", vid, words), {16'd0, cur_mem_addr},
                  {16'd0, exp_addr_q.pop_front()});
        end
        words++;
        last_hs = cyc;
      end
      if (cur_done) begin
        check($sformatf("v%0d_done_timing", vid), cyc, last_hs + 1);
        finished = 1'b1;
      end
      cyc++;
      @(negedge clk);
    end
    start = 1'b0;
    if (!finished) check($sformatf("v%0d_done_timeout", vid), 32'd0, 32'd1);
    check($sformatf("v%0d_idle_after_done", vid),
          {29'd0, cur_busy, cur_valid, cur_done}, 32'd0);
    check($sformatf("v%0d_word_count", vid), words, v.exp_words);
  endtask

  vec_t vecs[6];

  initial begin
    //           sel start    count  stall  cyc  inject words
    vecs[0] = '{0, 16'h3000, 16'd3, -1,    0,   -1,    12};
    vecs[1] = '{0, 16'h3000, 16'd3,  4,    5,   -1,    12};
    vecs[2] = '{0, 16'hFFFE, 16'd4, -1,    0,   -1,    13};
    vecs[3] = '{0, 16'h3000, 16'd0, -1,    0,   -1,     9};
    vecs[4] = '{0, 16'h3000, 16'd3, -1,    0,   10,    12};
    vecs[5] = '{1, 16'h1234, 16'd4, -1,    0,   -1,    13};

    // Reset values.
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    check("reset_dbg0", {30'd0, dbg0}, 32'd0);
    check("reset_dut1", {13'd0, if1.out_valid, busy1, done1, mem_addr1}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) run_dump(vecs[i], i);

    // Reset in the middle of the memory section, then a full dump again.
    begin
      int n;
      bit seen;
      sel = 0; n = 0; seen = 1'b0;
      @(negedge clk);
      start = 1'b1; start_addr = 16'h3000; count = 16'd3; ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      while (!seen && n < 100) begin
        if (cur_valid && cur_tag == 2'b10) seen = 1'b1;
        else begin
          n++;
          @(negedge clk);
        end
      end
      check("midrst_reached_mem", {31'd0, seen}, 32'd1);
      rst = 1'b1;
      #1;
      check_all_zero("midrst");
      @(negedge clk);
      check("midrst_no_done", {31'd0, done0}, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      run_dump(vecs[0], 6);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
